sd_port_arbiter: RTL
====================

# sd_port_arbiter

Shares one MiSTer HPS sector port (one image slot: `sd_lba`/`sd_rd`/`sd_wr`/`sd_ack` plus the byte-level buffer bus) between two requesters, the floppy controller (requester 0) and the SD controller (requester 1). Round-robin grant, one whole sector transaction per grant, buffer-bus routing to the owner only, and a no-ack timeout. Sits between the HPS `sd_*` arrays in the top level and the two disk controllers.

## Interface
Parameters:
- `TIMEOUT_W`, 24: width of the no-ack timeout counter. Timeout fires at 2^TIMEOUT_W−1 cycles.

Ports:
- `CLK` in 1: system clock. Single clock domain; all logic on posedge.
- `RESET` in 1: synchronous, active-high reset.
- `rq_lba` in 2×32: per-requester sector LBA. Sampled at grant.
- `rq_rd` in 2: per-requester read request. Level; held until that requester sees `rq_ack`.
- `rq_wr` in 2: per-requester write request. Same rules as `rq_rd`.
- `rq_ack` out 2: host ack forwarded to the owning requester only.
- `rq_done` out 2: one-cycle pulse at the end of the owner's transaction.
- `rq_err` out 2: one-cycle pulse when the owner's request times out.
- `rq_buff_wr` out 2: `sd_buff_wr`, gated to the owner.
- `rq_buff_din` in 2×8: per-requester buffer read data, for host writes.
- `sd_lba` out 32: LBA to host.
- `sd_rd` out 1: read request to host.
- `sd_wr` out 1: write request to host.
- `sd_ack` in 1: host ack.
- `sd_buff_din` out 8: muxed owner buffer data to host.
- `sd_buff_wr` in 1: host buffer write strobe.
- `busy` out 1: high when state ≠ IDLE.
- `owner` out 1: current or last granted requester.

`sd_buff_addr` and `sd_buff_dout` are broadcast directly to both requesters and do not pass through this block.

## Operation
- **States:** IDLE, REQ, XFER, DONE.
- **IDLE**
  - Pending set is P[i] = `rq_rd[i]` | `rq_wr[i]`.
  - If exactly one bit of P is set, grant that requester.
  - If both are set, grant `~last` (round-robin).
  - On grant: latch `owner`, latch `sd_lba` ← `rq_lba[owner]`, latch direction (`is_wr` = `rq_wr & ~rq_rd`; read wins if both are high), clear the timeout counter, go to REQ.
- **REQ**
  - Drive `sd_rd` = ~`is_wr`, `sd_wr` = `is_wr`; the counter increments.
  - On `sd_ack`=1: drop `sd_rd`/`sd_wr` and go to XFER.
  - On counter all-ones: pulse `rq_err[owner]`, drop the request, set `last` ← `owner`, go to IDLE.
- **XFER**
  - `rq_ack[owner]` = `sd_ack`.
  - `rq_buff_wr[owner]` = `sd_buff_wr & sd_ack`.
  - `sd_buff_din` = `rq_buff_din[owner]`.
  - On `sd_ack` falling (registered `ack_d`=1, `sd_ack`=0): go to DONE.
- **DONE**
  - Pulse `rq_done[owner]`, set `last` ← `owner`, go to IDLE.
- **Non-owner outputs:** `rq_ack`, `rq_buff_wr`, `rq_done` and `rq_err` for the non-owner are always 0.
- **`sd_buff_din` outside XFER:** equals `rq_buff_din[owner]`; it is harmless because the host only samples during ack.
- **Non-owner during a transaction:** its request is ignored until it is granted. It keeps its request held and is never dropped.
- **Owner releasing early:** if the owner drops `rq_rd`/`rq_wr` before ack, the transaction still completes. A host ack cannot be cancelled.

## Timing
- **Reset values:**
  - State IDLE, `last`=1 (so requester 0 wins the first tie), `owner`=0.
  - `sd_lba`=0, `sd_rd`=`sd_wr`=0.
  - `rq_ack`, `rq_done`, `rq_err`, `rq_buff_wr` all 0; `busy`=0; counter 0.
- **Grant latency:** request high in cycle N (IDLE) → `sd_rd`/`sd_wr` and `sd_lba` valid at cycle N+1 (registered).
- **Host ack:** `sd_ack` high in cycle M → `sd_rd`/`sd_wr` low at M+1.
- **Combinational forwarding:** `rq_ack`, `rq_buff_wr` and `sd_buff_din` follow inputs in the same cycle, muxed by registered `owner`.
- **Completion:** `sd_ack` falls in cycle K → DONE at K+1 (`rq_done` high for exactly that cycle) → IDLE at K+2.
- **Back-to-back:** the earliest next grant is sampled at K+2, so there are 2 dead cycles between transactions.
- **Timeout:** `rq_err` asserts 2^TIMEOUT_W−1 cycles after entering REQ. The counter saturates and does not wrap.
- **Reset mid-transaction:** all registers return to reset values in the next cycle. `sd_rd`/`sd_wr` are dropped even while the host ack is high. Requesters must re-request.
- **Ack already high on entry to REQ:** XFER is entered next cycle (no edge required). DONE is still edge-based.

## Structure
- Shared package `sdc_pkg`:
  - `arb_state_t` enum (IDLE, REQ, XFER, DONE).
  - `REQ_FDC`=0, `REQ_SDC`=1.
- Single module; no sub-module needed. Round-robin pick is a small function in the package.

## Test plan
- **Single read:** `rq_rd[1]`=1, `rq_lba[1]`=0x1234 → next cycle `sd_rd`=1, `sd_lba`=0x1234; host ack for 512 `sd_buff_wr` strobes → exactly 512 `rq_buff_wr[1]` pulses, 0 on `rq_buff_wr[0]`, one `rq_done[1]` pulse.
- **Tie after reset:** both `rq_rd` high → requester 0 served first, then requester 1. Repeat with both high → order 0,1,0,1.
- **Write path:** `rq_wr[0]`=1, `rq_buff_din[0]`=0xA5 → `sd_wr`=1, `sd_rd`=0, `sd_buff_din`=0xA5 during ack.
- **Simultaneous `rq_rd[0]` and `rq_wr[0]`:** read issued (`sd_rd`=1, `sd_wr`=0).
- **Timeout:** with `TIMEOUT_W`=4, no ack → `rq_err[owner]` pulse 15 cycles after REQ entry, `sd_rd` low, IDLE.
- **Reset during XFER:** after 100 strobes, assert RESET for 1 cycle → `sd_rd`/`sd_wr`/`rq_ack` all 0, `busy`=0, no `rq_done`.

Source files
------------

// File: rtl/sdc_pkg.sv
// Shared types for the HPS sector-port arbiter: FSM states, requester ids
// and the round-robin pick.
package sdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } arb_state_t;

  localparam logic REQ_FDC = 1'b0;
  localparam logic REQ_SDC = 1'b1;

  // On a tie the requester that was not served last wins.
  function automatic logic rr_pick(input logic [1:0] pending, input logic last);
    if (pending == 2'b11) return ~last;
    return pending[REQ_SDC];
  endfunction

endpackage

// File: rtl/sd_port_arbiter_if.sv
// Bundle of the requester-side and host-side sector port signals.
// master = arbiter view, slave = surrounding top level / requesters / host.
interface sd_port_arbiter_if;

  logic [1:0][31:0] rq_lba;
  logic [1:0]       rq_rd;
  logic [1:0]       rq_wr;
  logic [1:0]       rq_ack;
  logic [1:0]       rq_done;
  logic [1:0]       rq_err;
  logic [1:0]       rq_buff_wr;
  logic [1:0][7:0]  rq_buff_din;

  logic [31:0]      sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;
  logic [7:0]       sd_buff_din;
  logic             sd_buff_wr;

  modport master (
    input  rq_lba, rq_rd, rq_wr, rq_buff_din, sd_ack, sd_buff_wr,
    output rq_ack, rq_done, rq_err, rq_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport slave (
    output rq_lba, rq_rd, rq_wr, rq_buff_din, sd_ack, sd_buff_wr,
    input  rq_ack, rq_done, rq_err, rq_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

endinterface

// File: rtl/sd_port_arbiter.sv
// Round-robin sharing of one HPS sector port between the floppy controller
// (requester 0) and the SD controller (requester 1), with a no-ack timeout.
module sd_port_arbiter
  import sdc_pkg::*;
#(
  parameter int TIMEOUT_W = 24
) (
  input  logic                CLK,
  input  logic                RESET,
  sd_port_arbiter_if.master   bus,
  output logic                busy,
  output logic                owner
);

  arb_state_t           state;
  arb_state_t           state_next;
  logic                 last;
  logic                 ack_d;
  logic [TIMEOUT_W-1:0] cnt;
  logic [31:0]          lba_q;
  logic                 rd_q;
  logic                 wr_q;

  logic [1:0] pending;
  logic       grant_id;
  logic       grant_wr;
  logic       timeout;
  logic [1:0] ack_v;
  logic [1:0] bw_v;
  logic [1:0] done_v;
  logic [1:0] err_v;

  assign pending  = bus.rq_rd | bus.rq_wr;
  assign grant_id = rr_pick(pending, last);
  // Read wins when a requester raises both strobes.
  assign grant_wr = bus.rq_wr[grant_id] & ~bus.rq_rd[grant_id];
  assign timeout  = &cnt;

  always_comb begin
    state_next = state;
    ack_v      = 2'b00;
    bw_v       = 2'b00;
    done_v     = 2'b00;
    err_v      = 2'b00;
    case (state)
      IDLE: if (|pending) state_next = REQ;
      REQ: begin
        if (bus.sd_ack) begin
          state_next = XFER;
        end else if (timeout) begin
          err_v[owner] = 1'b1;
          state_next   = IDLE;
        end
      end
      XFER: begin
        ack_v[owner] = bus.sd_ack;
        bw_v[owner]  = bus.sd_buff_wr & bus.sd_ack;
        if (ack_d && !bus.sd_ack) state_next = DONE;
      end
      DONE: begin
        done_v[owner] = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      ack_d <= 1'b0;
      cnt   <= '0;
      lba_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      state <= state_next;
      ack_d <= bus.sd_ack;
      case (state)
        IDLE: begin
          if (|pending) begin
            owner <= grant_id;
            lba_q <= bus.rq_lba[grant_id];
            rd_q  <= ~grant_wr;
            wr_q  <= grant_wr;
            cnt   <= '0;
          end
        end
        REQ: begin
          // Saturate rather than wrap so a late ack can never re-arm the timeout.
          if (!timeout) cnt <= cnt + 1'b1;
          if (bus.sd_ack || timeout) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
          end
          if (!bus.sd_ack && timeout) last <= owner;
        end
        DONE:    last <= owner;
        default: ;
      endcase
    end
  end

  assign bus.sd_lba      = lba_q;
  assign bus.sd_rd       = rd_q;
  assign bus.sd_wr       = wr_q;
  assign bus.sd_buff_din = bus.rq_buff_din[owner];
  assign bus.rq_ack      = ack_v;
  assign bus.rq_buff_wr  = bw_v;
  assign bus.rq_done     = done_v;
  assign bus.rq_err      = err_v;
  assign busy            = (state != IDLE);

endmodule
